// File: rtl/instr_register_reader.sv
// Read-side sequencer for the instruction register: walks a programmed address
// range, executes each opcode and streams one result per instruction.
package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_register_reader
  import instr_register_pkg::*;
#(
  parameter int RES_W       = 64,
  parameter int NUM_ENTRIES = 32,
  localparam int AW         = $clog2(NUM_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW-1:0]           start_addr,
  input  logic [AW:0]             count,
  output logic [AW-1:0]           read_pointer,
  input  instruction_t            instruction_word,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [AW-1:0]           res_addr,
  output logic [3:0]              res_opcode,
  output logic signed [RES_W-1:0] result,
  output logic                    div_by_zero,
  output logic                    illegal_op,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

  localparam logic [AW:0] MAX_CNT = NUM_ENTRIES[AW:0];
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  state_t         state_q;
  logic [AW-1:0]  ptr_q;
  logic [AW:0]    rem_q;
  instruction_t   iw_q;

  logic [AW:0]             cnt_d;
  logic signed [RES_W-1:0] a_x, b_x, res_d;
  logic                    dz_d, il_d;

  assign cnt_d = (count > MAX_CNT) ? MAX_CNT : count;

  // Operands are widened first so MULT yields the full product and
  // DIV of -2^31 by -1 stays exact.
  always_comb begin
    a_x   = {{(RES_W-32){iw_q.op_a[31]}}, iw_q.op_a};
    b_x   = {{(RES_W-32){iw_q.op_b[31]}}, iw_q.op_b};
    res_d = '0;
    dz_d  = 1'b0;
    il_d  = 1'b0;
    case (iw_q.opc)
      ZERO:  res_d = '0;
      PASSA: res_d = a_x;
      PASSB: res_d = b_x;
      ADD:   res_d = a_x + b_x;
      SUB:   res_d = a_x - b_x;
      MULT:  res_d = a_x * b_x;
      DIV: begin
        if (b_x == '0) dz_d  = 1'b1;
        else           res_d = a_x / b_x;
      end
      MOD: begin
        if (b_x == '0) dz_d  = 1'b1;
        else           res_d = a_x % b_x;
      end
      default: il_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      iw_q         <= '0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_opcode   <= '0;
      result       <= '0;
      div_by_zero  <= 1'b0;
      illegal_op   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr_q <= start_addr;
            rem_q <= cnt_d;
            if (cnt_d == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              read_pointer <= start_addr;
              busy         <= 1'b1;
              state_q      <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          iw_q    <= instruction_word;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result      <= res_d;
          res_opcode  <= iw_q.opc;
          res_addr    <= ptr_q;
          div_by_zero <= dz_d;
          illegal_op  <= il_d;
          res_valid   <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            rem_q       <= rem_q - ONE;
            ptr_q       <= ptr_q + 1'b1;
            if (rem_q == ONE) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              read_pointer <= ptr_q + 1'b1;
              state_q      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
